// File: rtl/tone_pkg.sv
// Shared constants, FSM encoding and note classifier for the tone decoder.
package tone_pkg;

   localparam logic [2:0] NOTE_DO   = 3'd0;
   localparam logic [2:0] NOTE_RE   = 3'd1;
   localparam logic [2:0] NOTE_MI   = 3'd2;
   localparam logic [2:0] NOTE_FA   = 3'd3;
   localparam logic [2:0] NOTE_NONE = 3'd4;

   localparam int unsigned DEF_DIV_DO = 23860;
   localparam int unsigned DEF_DIV_RE = 21302;
   localparam int unsigned DEF_DIV_MI = 18977;
   localparam int unsigned DEF_DIV_FA = 17906;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   // 33-bit signed difference so a full-range meas can never wrap
   function automatic logic near(input logic [31:0] meas,
                                 input logic [31:0] div,
                                 input logic [31:0] tol);
      logic signed [32:0] d;
      d = $signed({1'b0, meas}) - $signed({1'b0, div});
      if (d < 0) d = -d;
      return (d <= $signed({1'b0, tol}));
   endfunction

   function automatic logic [2:0] classify(input logic [31:0] meas,
                                           input logic [31:0] d_do,
                                           input logic [31:0] d_re,
                                           input logic [31:0] d_mi,
                                           input logic [31:0] d_fa,
                                           input logic [31:0] tol);
      logic [2:0] n;
      n = NOTE_NONE;
      if (near(meas, d_do, tol))      n = NOTE_DO;
      else if (near(meas, d_re, tol)) n = NOTE_RE;
      else if (near(meas, d_mi, tol)) n = NOTE_MI;
      else if (near(meas, d_fa, tol)) n = NOTE_FA;
      return n;
   endfunction

   function automatic logic [3:0] onehot(input logic [2:0] n);
      logic [3:0] v;
      v = 4'b0000;
      if (n != NOTE_NONE) v[n[1:0]] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/tone_period_meter.sv
// Input synchronizer, either-polarity edge detect and saturating
// interval counter; meas is the edge-to-edge spacing in clk cycles.
module tone_period_meter #(
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_pwm,
   output logic        o_edge,
   output logic [31:0] o_meas,
   output logic        o_timeout
);

   logic        r_s1;
   logic        r_s2;
   logic        r_s3;
   logic [31:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_s3  <= 1'b0;
         r_cnt <= 32'd0;
      end else begin
         r_s1 <= i_pwm;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
         if (o_edge)
            r_cnt <= 32'd1;
         else if (r_cnt != TIMEOUT)
            r_cnt <= r_cnt + 32'd1;
      end
   end

   assign o_edge    = r_s2 ^ r_s3;
   assign o_meas    = r_cnt;
   assign o_timeout = (r_cnt == TIMEOUT);

endmodule

// File: rtl/tone_decoder.sv
// Tone decoder top: note classifier plus lock FSM.
// Optional TONE_DECODER_MEAS_EN adds the meas_out port.
module tone_decoder
   import tone_pkg::*;
#(
   parameter int unsigned CLK_HZ  = 25_000_000,
   parameter int unsigned DIV_DO  = DEF_DIV_DO,
   parameter int unsigned DIV_RE  = DEF_DIV_RE,
   parameter int unsigned DIV_MI  = DEF_DIV_MI,
   parameter int unsigned DIV_FA  = DEF_DIV_FA,
   parameter int unsigned TOL     = 256,
   parameter int unsigned CONFIRM = 3,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pwm_in,
`ifdef TONE_DECODER_MEAS_EN
   output logic [31:0] meas_out,
`endif
   output logic [3:0]  note_onehot,
   output logic        note_valid,
   output logic        note_pulse,
   output logic [31:0] note_counter
);

   if (CONFIRM < 1) begin : g_bad_confirm
      $error("CONFIRM must be at least 1");
   end
   if (CLK_HZ == 0) begin : g_bad_clk
      $error("CLK_HZ must be nonzero");
   end

   logic        w_edge;
   logic        w_timeout;
   logic [31:0] w_meas;
   logic [2:0]  w_class;
   logic [31:0] w_conf;

   state_t      r_state;
   logic [2:0]  r_cand;
   logic [31:0] r_confirm;
   logic [3:0]  r_onehot;
   logic        r_valid;
   logic        r_pulse;
   logic [31:0] r_count;

   tone_period_meter #(.TIMEOUT(TIMEOUT)) u_meter (
      .clk       (clk),
      .rst       (rst),
      .i_pwm     (pwm_in),
      .o_edge    (w_edge),
      .o_meas    (w_meas),
      .o_timeout (w_timeout)
   );

   assign w_class = classify(w_meas, DIV_DO, DIV_RE, DIV_MI, DIV_FA, TOL);
   assign w_conf  = (w_class == r_cand && r_cand != NOTE_NONE)
                  ? r_confirm + 32'd1
                  : {31'd0, w_class != NOTE_NONE};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cand    <= NOTE_NONE;
         r_confirm <= 32'd0;
         r_onehot  <= 4'b0000;
         r_valid   <= 1'b0;
         r_pulse   <= 1'b0;
         r_count   <= 32'd0;
      end else begin
         r_pulse <= 1'b0;
         // silence overrides any edge seen in the same cycle
         if (w_timeout) begin
            r_state   <= ST_IDLE;
            r_cand    <= NOTE_NONE;
            r_confirm <= 32'd0;
            r_onehot  <= 4'b0000;
            r_valid   <= 1'b0;
         end else if (w_edge) begin
            unique case (r_state)
               ST_IDLE: begin
                  r_state   <= ST_TRACK;
                  r_cand    <= NOTE_NONE;
                  r_confirm <= 32'd0;
               end
               ST_TRACK: begin
                  r_cand    <= w_class;
                  r_confirm <= w_conf;
                  if (w_conf >= CONFIRM) begin
                     r_state  <= ST_LOCKED;
                     r_valid  <= 1'b1;
                     r_onehot <= onehot(w_class);
                     r_pulse  <= 1'b1;
                     r_count  <= r_count + 32'd1;
                  end
               end
               ST_LOCKED: begin
                  if (w_class != r_cand) begin
                     r_state   <= ST_TRACK;
                     r_cand    <= w_class;
                     r_confirm <= {31'd0, w_class != NOTE_NONE};
                     r_valid   <= 1'b0;
                     r_onehot  <= 4'b0000;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef TONE_DECODER_MEAS_EN
   logic [31:0] r_meas;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_meas <= 32'd0;
      else if (w_edge)
         r_meas <= w_meas;
   end

   assign meas_out = r_meas;
`endif

   assign note_onehot  = r_onehot;
   assign note_valid   = r_valid;
   assign note_pulse   = r_pulse;
   assign note_counter = r_count;

endmodule
